// File: rtl/sn_stream_decoder_pkg.sv
// Shared stochastic-computing package.
// Holds the default SN length limits, the decoder/generator state encoding
// and the window-length clamp used wherever a programmable L is latched.
package sn_stream_decoder_pkg;

   // Longest supported stream is 2^LEN_W bits.
   localparam int LEN_W = 27;
   // Width of len_log2; 2^LOG_W must exceed LEN_W.
   localparam int LOG_W = 5;
   // Count width; holds 2^LEN_W inclusive.
   localparam int CNT_W = LEN_W + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } sn_state_e;

   // Clamp a requested window length into the legal range [1, lmax].
   // A zero-length window is promoted to two bits so a window always
   // has at least one terminal compare to hit.
   function automatic logic [LOG_W-1:0] clamp_len(input logic [LOG_W-1:0] l,
                                                  input logic [LOG_W-1:0] lmax);
      logic [LOG_W-1:0] r;
      if (l == {LOG_W{1'b0}}) begin
         r = LOG_W'(1);
      end else if (l > lmax) begin
         r = lmax;
      end else begin
         r = l;
      end
      return r;
   endfunction

endpackage

// File: rtl/sn_window_counter.sv
// Sample counter for one SN decode window.
// Counts accepted bits and flags the accepted bit that completes a window
// of 2^l_eff samples.
// Ports:
//   clk_i      system clock, rising edge
//   reset_i    synchronous active-high reset
//   clear_i    restart the count at the beginning of a window
//   inc_i      a bit is accepted this cycle
//   l_eff_i    clamped window length exponent
//   last_bit_o the bit accepted this cycle is the final one of the window
module sn_window_counter
   import sn_stream_decoder_pkg::*;
#(
   parameter int W_LOG = LOG_W,
   parameter int W_CNT = CNT_W
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             clear_i,
   input  logic             inc_i,
   input  logic [W_LOG-1:0] l_eff_i,
   output logic             last_bit_o
);

   logic [W_CNT-1:0] samples_q;
   logic [W_CNT-1:0] samples_d;
   logic [W_CNT-1:0] term_s;

   // Terminal value of the window and the next-sample count.
   always_comb begin
      term_s    = W_CNT'(1) << l_eff_i;
      samples_d = samples_q;
      if (clear_i) begin
         samples_d = {W_CNT{1'b0}};
      end else if (inc_i) begin
         samples_d = samples_q + W_CNT'(1);
      end else begin
         samples_d = samples_q;
      end
   end

   // The compare looks at the post-increment count so the flag rises on
   // the very bit that makes samples equal the window size.
   assign last_bit_o = inc_i && (samples_q + W_CNT'(1) == term_s);

   // Sample counter register.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         samples_q <= {W_CNT{1'b0}};
      end else begin
         samples_q <= samples_d;
      end
   end

endmodule

// File: rtl/sn_stream_decoder.sv
// Stochastic-number to binary decoder.
// Counts the ones in a unipolar bitstream of 2^L bits and reports the raw
// count plus a Q1.LEN_W probability (2^LEN_W == 1.0).
// Ports:
//   clk_i        system clock, rising edge
//   reset_i      synchronous active-high reset
//   start_i      begin a window (honoured only in IDLE)
//   len_log2_i   window length exponent L, latched on start
//   bit_in_i     SN bit
//   bit_valid_i  qualifies bit_in_i during RUN
//   busy_o       window in progress (falls with the done pulse)
//   done_o       one-cycle pulse when count/prob update
//   valid_o      count/prob hold a completed result
//   count_o      ones in the last completed window
//   prob_o       count scaled to Q1.LEN_W
module sn_stream_decoder
   import sn_stream_decoder_pkg::*;
(
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             start_i,
   input  logic [LOG_W-1:0] len_log2_i,
   input  logic             bit_in_i,
   input  logic             bit_valid_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             valid_o,
   output logic [CNT_W-1:0] count_o,
   output logic [CNT_W-1:0] prob_o
);

   sn_state_e        state_q, state_d;
   logic [LOG_W-1:0] l_eff_q;
   logic [CNT_W-1:0] ones_q;
   logic             start_acc_s;
   logic             accept_s;
   logic             last_bit_s;
   logic [LOG_W-1:0] shamt_s;
   logic             busy_q, done_q, valid_q;
   logic [CNT_W-1:0] count_q, prob_q;

   sn_window_counter #(
      .W_LOG (LOG_W),
      .W_CNT (CNT_W)
   ) u_win (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .clear_i    (start_acc_s),
      .inc_i      (accept_s),
      .l_eff_i    (l_eff_q),
      .last_bit_o (last_bit_s)
   );

   // Next-state logic and per-cycle strobes.
   always_comb begin
      state_d     = state_q;
      start_acc_s = 1'b0;
      accept_s    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               start_acc_s = 1'b1;
               state_d     = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            if (bit_valid_i) begin
               accept_s = 1'b1;
               state_d  = last_bit_s ? FIN : RUN;
            end else begin
               state_d = RUN;
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Normaliser shift: a full window of 2^l_eff ones lands on 2^LEN_W.
   assign shamt_s = LOG_W'(LEN_W) - l_eff_q;

   // State, accumulator and registered result outputs.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         l_eff_q <= {LOG_W{1'b0}};
         ones_q  <= {CNT_W{1'b0}};
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         valid_q <= 1'b0;
         count_q <= {CNT_W{1'b0}};
         prob_q  <= {CNT_W{1'b0}};
      end else begin
         state_q <= state_d;
         // busy spans RUN and FIN so it drops on the same edge done rises.
         busy_q  <= (state_d != IDLE);
         done_q  <= (state_q == FIN);
         if (start_acc_s) begin
            l_eff_q <= clamp_len(len_log2_i, LOG_W'(LEN_W));
            ones_q  <= {CNT_W{1'b0}};
            valid_q <= 1'b0;
         end else if (accept_s) begin
            ones_q  <= ones_q + CNT_W'(bit_in_i);
         end else if (state_q == FIN) begin
            count_q <= ones_q;
            prob_q  <= ones_q << shamt_s;
            valid_q <= 1'b1;
         end else begin
            ones_q  <= ones_q;
         end
      end
   end

   assign busy_o  = busy_q;
   assign done_o  = done_q;
   assign valid_o = valid_q;
   assign count_o = count_q;
   assign prob_o  = prob_q;

endmodule
